// File: rtl/csr_timer_scheduler.sv
// CSR-mapped timer scheduler: prescaled tick generator for an external 64-bit counter
// plus a compare FSM (IDLE/ARMED/FIRED) that raises a registered interrupt request.
module csr_timer_scheduler #(
    parameter logic [11:0] ADDRESS_CTRL      = 12'h000,
    parameter logic [11:0] ADDRESS_CMP_LOWER = 12'h000,
    parameter logic [11:0] ADDRESS_CMP_UPPER = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csrReadEnable,
    input  logic        csrWriteEnable,
    input  logic [11:0] csrAddress,
    input  logic [31:0] csrWriteData,
    output logic [31:0] csrReadData,
    output logic        csrRequestOutput,
    input  logic [63:0] timerValue,
    output logic        timerCount,
    output logic        interruptPending
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FIRED = 2'd2;

    logic        count_enable_r;
    logic        interrupt_enable_r;
    logic [15:0] divisor_r;
    logic [15:0] prescaler_r;
    logic        timer_count_r;
    logic [63:0] compare_r;
    logic [1:0]  state_r;
    logic [1:0]  state_next_s;
    logic        fired_s;
    logic        interrupt_pending_r;
    logic        hit_ctrl_s;
    logic        hit_lower_s;
    logic        hit_upper_s;
    logic        wr_ctrl_s;
    logic        wr_lower_s;
    logic        wr_upper_s;
    logic        match_s;
    logic        unused_s;

    // Address decode and write strobes
    always_comb begin
        hit_ctrl_s  = (csrAddress == ADDRESS_CTRL);
        hit_lower_s = (csrAddress == ADDRESS_CMP_LOWER);
        hit_upper_s = (csrAddress == ADDRESS_CMP_UPPER);
        wr_ctrl_s   = csrWriteEnable && hit_ctrl_s;
        wr_lower_s  = csrWriteEnable && hit_lower_s;
        wr_upper_s  = csrWriteEnable && hit_upper_s;
        match_s     = (timerValue >= compare_r);
        unused_s    = ^csrWriteData[15:4];
    end

    // Control register fields
    always_ff @(posedge clk) begin
        if (rst) begin
            count_enable_r     <= 1'b0;
            interrupt_enable_r <= 1'b0;
            divisor_r          <= 16'd0;
        end else if (wr_ctrl_s) begin
            count_enable_r     <= csrWriteData[0];
            interrupt_enable_r <= csrWriteData[1];
            divisor_r          <= csrWriteData[31:16];
        end
    end

    // Prescaler; a CTRL write restarts the period so a new divisor starts cleanly
    always_ff @(posedge clk) begin
        if (rst || wr_ctrl_s) begin
            prescaler_r   <= 16'd0;
            timer_count_r <= 1'b0;
        end else if (count_enable_r) begin
            if (prescaler_r == divisor_r) begin
                prescaler_r   <= 16'd0;
                timer_count_r <= 1'b1;
            end else begin
                prescaler_r   <= prescaler_r + 16'd1;
                timer_count_r <= 1'b0;
            end
        end else begin
            timer_count_r <= 1'b0;
        end
    end

    // 64-bit compare value, written one half at a time
    always_ff @(posedge clk) begin
        if (rst) begin
            compare_r <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            if (wr_lower_s) begin
                compare_r[31:0] <= csrWriteData;
            end
            if (wr_upper_s) begin
                compare_r[63:32] <= csrWriteData;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; compare writes take priority over a simultaneous match
    always_comb begin
        state_next_s = state_r;
        if (wr_lower_s) begin
            state_next_s = ST_IDLE;
        end else if (wr_upper_s) begin
            state_next_s = ST_ARMED;
        end else begin
            case (state_r)
                ST_IDLE:  state_next_s = ST_IDLE;
                ST_ARMED: state_next_s = match_s ? ST_FIRED : ST_ARMED;
                ST_FIRED: state_next_s = (wr_ctrl_s && csrWriteData[3]) ? ST_IDLE : ST_FIRED;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        fired_s = (state_r == ST_FIRED);
    end

    // Registered interrupt request
    always_ff @(posedge clk) begin
        if (rst) begin
            interrupt_pending_r <= 1'b0;
        end else begin
            interrupt_pending_r <= fired_s && interrupt_enable_r;
        end
    end

    // CSR read mux; the clear bit always reads back as 0
    always_comb begin
        csrReadData      = 32'd0;
        csrRequestOutput = csrReadEnable && (hit_ctrl_s || hit_lower_s || hit_upper_s);
        if (!csrReadEnable) begin
            csrReadData = 32'd0;
        end else if (hit_ctrl_s) begin
            csrReadData = {divisor_r, 10'd0, state_r, 1'b0, fired_s,
                           interrupt_enable_r, count_enable_r};
        end else if (hit_lower_s) begin
            csrReadData = compare_r[31:0];
        end else if (hit_upper_s) begin
            csrReadData = compare_r[63:32];
        end else begin
            csrReadData = 32'd0;
        end
    end

    assign timerCount       = timer_count_r;
    assign interruptPending = interrupt_pending_r;

endmodule

// File: tb/tb_csr_timer_scheduler.sv
// Self-checking bench for csr_timer_scheduler: read-decode vector table, tick-stream
// scoreboard and hand-written sequences for the compare FSM and reset corners.
module tb_csr_timer_scheduler;

    localparam logic [11:0] A_CTRL = 12'h7C0;
    localparam logic [11:0] A_LO   = 12'h7C1;
    localparam logic [11:0] A_UP   = 12'h7C2;

    logic        clk;
    logic        rst;
    logic        csrReadEnable;
    logic        csrWriteEnable;
    logic [11:0] csrAddress;
    logic [31:0] csrWriteData;
    logic [31:0] csrReadData;
    logic        csrRequestOutput;
    logic [63:0] timerValue;
    logic        timerCount;
    logic        interruptPending;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    typedef struct {
        logic        re;
        logic [11:0] addr;
        logic        exp_req;
        logic [31:0] exp_data;
    } rd_vec_t;

    rd_vec_t rd_tab[6];

    csr_timer_scheduler #(
        .ADDRESS_CTRL(A_CTRL),
        .ADDRESS_CMP_LOWER(A_LO),
        .ADDRESS_CMP_UPPER(A_UP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .csrReadEnable(csrReadEnable),
        .csrWriteEnable(csrWriteEnable),
        .csrAddress(csrAddress),
        .csrWriteData(csrWriteData),
        .csrReadData(csrReadData),
        .csrRequestOutput(csrRequestOutput),
        .timerValue(timerValue),
        .timerCount(timerCount),
        .interruptPending(interruptPending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csrAddress     = a;
        csrWriteData   = d;
        csrWriteEnable = 1'b1;
        tick();
        csrWriteEnable = 1'b0;
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
        csrAddress    = a;
        csrReadEnable = 1'b1;
        #1;
        d             = csrReadData;
        csrReadEnable = 1'b0;
    endtask

    task automatic check_state(input string name, input logic [1:0] exp);
        logic [31:0] d;
        csr_read(A_CTRL, d);
        check(name, {62'd0, d[5:4]}, {62'd0, exp});
    endtask

    task automatic run_tc_stream(input string name, input int n);
        logic e;
        for (int i = 0; i < n; i++) begin
            tick();
            if (exp_q.size() == 0) begin
                check({name, "_sb_empty"}, 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check(name, {63'd0, timerCount}, {63'd0, e});
            end
        end
    endtask

    initial begin
        logic [31:0] d;

        rst_setup();
        rd_tab[0] = '{1'b1, A_CTRL,   1'b1, 32'h0000_0000};
        rd_tab[1] = '{1'b1, A_LO,     1'b1, 32'hFFFF_FFFF};
        rd_tab[2] = '{1'b1, A_UP,     1'b1, 32'hFFFF_FFFF};
        rd_tab[3] = '{1'b0, A_LO,     1'b0, 32'h0000_0000};
        rd_tab[4] = '{1'b1, 12'h123,  1'b0, 32'h0000_0000};
        rd_tab[5] = '{1'b0, A_CTRL,   1'b0, 32'h0000_0000};

        tick();
        tick();
        rst = 1'b0;
        check("rst_tc", {63'd0, timerCount}, 64'd0);
        check("rst_irq", {63'd0, interruptPending}, 64'd0);

        for (int i = 0; i < 6; i++) begin
            csrAddress    = rd_tab[i].addr;
            csrReadEnable = rd_tab[i].re;
            #1;
            check($sformatf("rd_req_%0d", i), {63'd0, csrRequestOutput}, {63'd0, rd_tab[i].exp_req});
            check($sformatf("rd_data_%0d", i), {32'd0, csrReadData}, {32'd0, rd_tab[i].exp_data});
            csrReadEnable = 1'b0;
        end

        // divisor 3: tick every 4 cycles, first one 4 cycles after the write
        csr_write(A_CTRL, 32'h0003_0001);
        csr_read(A_CTRL, d);
        check("ctrl_rdback", {32'd0, d}, 64'h0003_0001);
        for (int n = 1; n <= 12; n++) exp_q.push_back((n % 4) == 0);
        run_tc_stream("tc_div3", 12);

        csr_write(A_CTRL, 32'h0000_0001);
        for (int n = 0; n < 4; n++) exp_q.push_back(1'b1);
        run_tc_stream("tc_div0", 4);

        csr_write(A_CTRL, 32'h0003_0000);
        for (int n = 0; n < 6; n++) exp_q.push_back(1'b0);
        run_tc_stream("tc_disabled", 6);

        // compare = 10, ramp timer
        timerValue = 64'd0;
        csr_write(A_CTRL, 32'h0000_0002);
        csr_write(A_LO, 32'd10);
        csr_read(A_LO, d);
        check("cmp_lo_rd", {32'd0, d}, 64'd10);
        check_state("st_idle_after_lo", 2'd0);
        csr_write(A_UP, 32'd0);
        check_state("st_armed_after_up", 2'd1);
        for (int tv = 0; tv < 10; tv++) begin
            timerValue = 64'(tv);
            tick();
            check_state($sformatf("st_armed_tv%0d", tv), 2'd1);
        end
        timerValue = 64'd10;
        tick();
        check_state("st_fired", 2'd2);
        check("irq_lag", {63'd0, interruptPending}, 64'd0);
        tick();
        check("irq_set", {63'd0, interruptPending}, 64'd1);

        // clear from FIRED, then re-arm with timer already past compare
        csr_write(A_CTRL, 32'h0000_000A);
        csr_read(A_CTRL, d);
        check("ctrl_after_clear", {32'd0, d}, 64'h0000_0002);
        tick();
        check("irq_cleared", {63'd0, interruptPending}, 64'd0);
        csr_write(A_UP, 32'd0);
        check_state("st_rearmed", 2'd1);
        tick();
        check_state("st_refired", 2'd2);
        tick();
        check("irq_refired", {63'd0, interruptPending}, 64'd1);

        // interrupts disabled while FIRED
        csr_write(A_CTRL, 32'h0000_0000);
        tick();
        check("irq_masked", {63'd0, interruptPending}, 64'd0);
        csr_read(A_CTRL, d);
        check("ctrl_masked_fired", {32'd0, d}, 64'h0000_0024);

        // CMP_UPPER write in the same cycle the old compare matches
        timerValue = 64'd50;
        csr_write(A_LO, 32'd100);
        csr_write(A_UP, 32'd0);
        check_state("st_armed_100", 2'd1);
        timerValue = 64'd150;
        csr_write(A_UP, 32'd1);
        check_state("st_write_wins", 2'd1);
        for (int n = 0; n < 3; n++) begin
            tick();
            check_state($sformatf("st_no_fire_%0d", n), 2'd1);
        end
        csr_read(A_UP, d);
        check("cmp_up_rd", {32'd0, d}, 64'd1);
        timerValue = 64'h0000_0001_0000_0064;
        tick();
        check_state("st_fire_new_cmp", 2'd2);

        // all-ones compare fires only at the all-ones timer value
        timerValue = 64'hFFFF_FFFF_FFFF_FFFE;
        csr_write(A_LO, 32'hFFFF_FFFF);
        csr_write(A_UP, 32'hFFFF_FFFF);
        tick();
        check_state("st_max_minus1", 2'd1);
        timerValue = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        check_state("st_max_fire", 2'd2);

        // reset mid-period with a competing CTRL write
        csr_write(A_CTRL, 32'h0005_0001);
        tick();
        tick();
        tick();
        rst            = 1'b1;
        csrAddress     = A_CTRL;
        csrWriteData   = 32'h0005_0003;
        csrWriteEnable = 1'b1;
        tick();
        rst            = 1'b0;
        csrWriteEnable = 1'b0;
        check("rst_mid_tc", {63'd0, timerCount}, 64'd0);
        csr_read(A_CTRL, d);
        check("rst_mid_ctrl", {32'd0, d}, 64'd0);
        csr_read(A_LO, d);
        check("rst_mid_lo", {32'd0, d}, 64'hFFFF_FFFF);
        csr_read(A_UP, d);
        check("rst_mid_up", {32'd0, d}, 64'hFFFF_FFFF);
        for (int n = 0; n < 8; n++) exp_q.push_back(1'b0);
        run_tc_stream("tc_after_rst", 8);
        check("rst_mid_irq", {63'd0, interruptPending}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic rst_setup();
        rst            = 1'b1;
        csrReadEnable  = 1'b0;
        csrWriteEnable = 1'b0;
        csrAddress     = 12'h000;
        csrWriteData   = 32'd0;
        timerValue     = 64'd0;
    endtask

endmodule
